// File: rtl/branch_resolve.sv
// Branch resolver: registers a request, asks an external comparator, returns taken/target.
// Latency: out_valid 2 cycles after accept; holds in DONE until out_ready, so no accept while busy.
module branch_resolve (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic        signed_en,
    input  logic [1:0]  cmp_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [31:0] out_target,
    output logic        out_illegal,
    output logic        out_misaligned,
    input  logic        flush,
    output logic [15:0] taken_cnt
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RESOLVE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d, imm_q, imm_d;
    logic        taken_q, taken_d, illegal_q, illegal_d, misaligned_q, misaligned_d;
    logic [31:0] target_q, target_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    logic        eq, lt, br_taken, br_illegal;
    logic [31:0] br_target;

    // cmp_res 11 falls out as neither equal nor less-than.
    assign eq = (cmp_res == 2'b01);
    assign lt = (cmp_res == 2'b10);

    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (funct3_q)
            3'b000:          br_taken = eq;
            3'b001:          br_taken = !eq;
            3'b100, 3'b110:  br_taken = lt;
            3'b101, 3'b111:  br_taken = !lt;
            default:         br_illegal = 1'b1;
        endcase
        br_target = br_taken ? (pc_q + imm_q) : (pc_q + 32'd4);
    end

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        taken_d      = taken_q;
        target_d     = target_q;
        illegal_d    = illegal_q;
        misaligned_d = misaligned_q;
        taken_cnt_d  = taken_cnt_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        funct3_d = funct3;
                        rs1_d    = rs1_val;
                        rs2_d    = rs2_val;
                        pc_d     = pc;
                        imm_d    = imm;
                        state_d  = S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    taken_d      = br_taken;
                    target_d     = br_target;
                    illegal_d    = br_illegal;
                    misaligned_d = br_taken && (br_target[1:0] != 2'b00);
                    state_d      = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (taken_q && (taken_cnt_q != 16'hFFFF))
                            taken_cnt_d = taken_cnt_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            funct3_q     <= 3'b000;
            rs1_q        <= 32'd0;
            rs2_q        <= 32'd0;
            pc_q         <= 32'd0;
            imm_q        <= 32'd0;
            taken_q      <= 1'b0;
            target_q     <= 32'd0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            taken_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign out_valid      = (state_q == S_DONE);
    assign cmp_a          = rs1_q;
    assign cmp_b          = rs2_q;
    assign signed_en      = (funct3_q[2:1] == 2'b10);
    assign out_taken      = taken_q;
    assign out_target     = target_q;
    assign out_illegal    = illegal_q;
    assign out_misaligned = misaligned_q;
    assign taken_cnt      = taken_cnt_q;
endmodule
